// File: rtl/nmea_sentence_filter.sv
// nmea_sentence_filter
// Frames NMEA sentences ('$' .. LF) out of a raw GPS byte stream, verifies the
// XOR checksum and forwards only complete, intact sentences downstream. One
// sentence is buffered so corrupt or partial sentences never reach the host.
// Optional feature macro: NMEA_ERR_COUNT_EN -- when defined, err_cnt is a
// saturating count of discarded sentences; otherwise err_cnt is tied to zero.
module nmea_sentence_filter #(
  parameter int MAX_LEN = 82
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sentence_ok,
  output logic        sentence_err,
  output logic        in_sentence,
  output logic [15:0] err_cnt
);

  localparam int               LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    BODY,
    CK_HI,
    CK_LO,
    WAIT_CR,
    WAIT_LF,
    DUMP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] rd_ptr;
  logic [7:0]       csum;
  logic [7:0]       rx_csum;
  logic [7:0]       sent_buf [MAX_LEN];

  logic       accept;
  logic       hex_ok;
  logic [3:0] hex_nib;

  logic do_start;
  logic do_store;
  logic do_xor;
  logic do_hi;
  logic do_lo;
  logic do_ok;
  logic do_err;
  logic rd_step;
  logic rd_done;

  assign in_ready    = (state != DUMP);
  assign out_valid   = (state == DUMP);
  assign out_data    = out_valid ? sent_buf[rd_ptr] : 8'h00;
  assign in_sentence = (state == BODY) || (state == CK_HI) || (state == CK_LO) ||
                       (state == WAIT_CR) || (state == WAIT_LF);
  assign accept      = in_valid && in_ready;

  // Decode an uppercase hex digit of the received checksum into its nibble
  always_comb begin
    hex_ok  = 1'b0;
    hex_nib = 4'h0;
    if ((in_data >= 8'h30) && (in_data <= 8'h39)) begin
      hex_ok  = 1'b1;
      hex_nib = in_data[3:0];
    end else if ((in_data >= 8'h41) && (in_data <= 8'h46)) begin
      hex_ok  = 1'b1;
      hex_nib = in_data[3:0] + 4'd9;
    end
  end

  // Next-state and datapath control: framing, restart, overflow and checksum decisions
  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_store  = 1'b0;
    do_xor    = 1'b0;
    do_hi     = 1'b0;
    do_lo     = 1'b0;
    do_ok     = 1'b0;
    do_err    = 1'b0;
    rd_step   = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (in_data == CH_DOLLAR)) begin
          do_start  = 1'b1;
          state_nxt = BODY;
        end
      end
      BODY, CK_HI, CK_LO, WAIT_CR, WAIT_LF: begin
        if (accept) begin
          if (in_data == CH_DOLLAR) begin
            do_start  = 1'b1;
            do_err    = 1'b1;
            state_nxt = BODY;
          end else if (len == LEN_MAX) begin
            do_err    = 1'b1;
            state_nxt = IDLE;
          end else begin
            case (state)
              BODY: begin
                if ((in_data == CH_CR) || (in_data == CH_LF)) begin
                  do_err    = 1'b1;
                  state_nxt = IDLE;
                end else if (in_data == CH_STAR) begin
                  do_store  = 1'b1;
                  state_nxt = CK_HI;
                end else begin
                  do_store = 1'b1;
                  do_xor   = 1'b1;
                end
              end
              CK_HI: begin
                if (hex_ok) begin
                  do_store  = 1'b1;
                  do_hi     = 1'b1;
                  state_nxt = CK_LO;
                end else begin
                  do_err    = 1'b1;
                  state_nxt = IDLE;
                end
              end
              CK_LO: begin
                if (hex_ok) begin
                  do_store  = 1'b1;
                  do_lo     = 1'b1;
                  state_nxt = WAIT_CR;
                end else begin
                  do_err    = 1'b1;
                  state_nxt = IDLE;
                end
              end
              WAIT_CR: begin
                if (in_data == CH_CR) begin
                  do_store  = 1'b1;
                  state_nxt = WAIT_LF;
                end else begin
                  do_err    = 1'b1;
                  state_nxt = IDLE;
                end
              end
              WAIT_LF: begin
                if (in_data == CH_LF) begin
                  do_store = 1'b1;
                  if (rx_csum == csum) begin
                    do_ok     = 1'b1;
                    state_nxt = DUMP;
                  end else begin
                    do_err    = 1'b1;
                    state_nxt = IDLE;
                  end
                end else begin
                  do_err    = 1'b1;
                  state_nxt = IDLE;
                end
              end
              default: begin
                state_nxt = IDLE;
              end
            endcase
          end
        end
      end
      DUMP: begin
        if (out_ready) begin
          if (rd_ptr == (len - LEN_ONE)) begin
            rd_done   = 1'b1;
            state_nxt = IDLE;
          end else begin
            rd_step = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sentence length, running checksum, received checksum and dump read pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len     <= '0;
      csum    <= 8'h00;
      rx_csum <= 8'h00;
      rd_ptr  <= '0;
    end else begin
      if (do_start) begin
        len  <= LEN_ONE;
        csum <= 8'h00;
      end else begin
        if (do_store) begin
          len <= len + LEN_ONE;
        end
        if (do_xor) begin
          csum <= csum ^ in_data;
        end
      end
      if (do_hi) begin
        rx_csum[7:4] <= hex_nib;
      end
      if (do_lo) begin
        rx_csum[3:0] <= hex_nib;
      end
      if (rd_done) begin
        rd_ptr <= '0;
      end else if (rd_step) begin
        rd_ptr <= rd_ptr + LEN_ONE;
      end
    end
  end

  // Sentence buffer write port; contents only matter once overwritten by a new sentence
  always_ff @(posedge clk) begin
    if (do_start) begin
      sent_buf[0] <= CH_DOLLAR;
    end else if (do_store) begin
      sent_buf[len] <= in_data;
    end
  end

  // One-cycle status pulses, registered so they are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sentence_ok  <= 1'b0;
      sentence_err <= 1'b0;
    end else begin
      sentence_ok  <= do_ok;
      sentence_err <= do_err;
    end
  end

`ifdef NMEA_ERR_COUNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of discarded sentences
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 16'h0000;
    end else if (do_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'h0001;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_nmea_sentence_filter.sv
// tb_nmea_sentence_filter
// Directed scenarios plus randomized byte streams for nmea_sentence_filter,
// checked against a sentence-level reference model kept in this bench.
module tb_nmea_sentence_filter;

  localparam int MAX_LEN = 82;

  typedef logic [7:0] u8_t;
  typedef u8_t bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  u8_t         in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  u8_t         out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sentence_ok;
  logic        sentence_err;
  logic        in_sentence;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  int  ready_mode = 0;
  int  ok_pulses = 0;
  int  err_pulses = 0;
  bit  pend = 1'b0;
  u8_t pend_data = 8'h00;

  u8_t rcv_q[$];
  u8_t exp_q[$];
  u8_t cur[$];
  u8_t item[$];
  int  model_ok = 0;
  int  model_err = 0;
  int  model_cnt = 0;

  nmea_sentence_filter #(.MAX_LEN(MAX_LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sentence_ok  (sentence_ok),
    .sentence_err (sentence_err),
    .in_sentence  (in_sentence),
    .err_cnt      (err_cnt)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Output monitor: counts pulses, drives out_ready, collects delivered bytes, checks hold stability
  always @(negedge clk) begin
    if (sentence_ok === 1'b1) ok_pulses++;
    if (sentence_err === 1'b1) err_pulses++;
    if (pend && rst_n) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== pend_data) begin
        errors++;
        $display("[TB] FAIL hold_stable: out_valid=%b out_data=%02h, required 1 / %02h",
                 out_valid, out_data, pend_data);
      end
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
    if (out_valid === 1'b1 && out_ready) rcv_q.push_back(out_data);
    pend      = (out_valid === 1'b1) && !out_ready;
    pend_data = out_data;
  end

  function automatic int cnt_if(int n);
`ifdef NMEA_ERR_COUNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  function automatic bit is_hex(u8_t b);
    return ((b >= 8'h30) && (b <= 8'h39)) || ((b >= 8'h41) && (b <= 8'h46));
  endfunction

  function automatic int hex_val(u8_t b);
    return (b <= 8'h39) ? int'(b) - 48 : int'(b) - 55;
  endfunction

  function automatic u8_t hex_char(logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic bq_t mk_sentence(string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(u8_t'(s[i]));
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  function automatic int q_diffs(bq_t a, bq_t b);
    int d = 0;
    if (a.size() != b.size()) d++;
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) d++;
    return d;
  endfunction

  // Reference model: 0 = candidate broken, 1 = valid so far, 2 = complete sentence
  function automatic int prefix_status();
    int star = -1;
    int rel;
    for (int i = 1; i < cur.size(); i++) begin
      if (star < 0) begin
        if (cur[i] == 8'h2A) star = i;
        else if (cur[i] == 8'h0D || cur[i] == 8'h0A) return 0;
      end else begin
        rel = i - star;
        if ((rel == 1 || rel == 2) && !is_hex(cur[i])) return 0;
        if (rel == 3 && cur[i] != 8'h0D) return 0;
        if (rel == 4 && cur[i] != 8'h0A) return 0;
        if (rel > 4) return 0;
      end
    end
    if (star >= 0 && cur.size() == star + 5) return 2;
    return 1;
  endfunction

  function automatic bit checksum_good();
    int  star = 0;
    u8_t x = 8'h00;
    for (int i = 1; i < cur.size(); i++) if (cur[i] == 8'h2A) begin star = i; break; end
    for (int i = 1; i < star; i++) x ^= cur[i];
    return int'(x) == (hex_val(cur[star + 1]) * 16 + hex_val(cur[star + 2]));
  endfunction

  function automatic void note_err();
    model_err++;
    if (model_cnt < 65535) model_cnt++;
  endfunction

  function automatic void model_byte(u8_t b);
    int st;
    if (b == 8'h24) begin
      if (cur.size() > 0) note_err();
      cur.delete();
      cur.push_back(b);
      return;
    end
    if (cur.size() == 0) return;
    if (cur.size() == MAX_LEN) begin
      note_err();
      cur.delete();
      return;
    end
    cur.push_back(b);
    st = prefix_status();
    if (st == 0) begin
      note_err();
      cur.delete();
    end else if (st == 2) begin
      if (checksum_good()) begin
        model_ok++;
        foreach (cur[i]) exp_q.push_back(cur[i]);
      end else begin
        note_err();
      end
      cur.delete();
    end
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    cur.delete();
    exp_q.delete();
    rcv_q.delete();
    model_cnt = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic send_byte(input u8_t b, input int gap);
    int budget = 0;
    @(negedge clk);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin
        in_data = u8_t'($urandom_range(0, 255));
        @(negedge clk);
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, budget);
    end else begin
      model_byte(b);
    end
  endtask

  task automatic send_seq(input bq_t q, input int gap_max);
    foreach (q[i]) send_byte(q[i], $urandom_range(0, gap_max));
  endtask

  task automatic drain(output bit timed_out);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while ((out_valid === 1'b1 || rcv_q.size() < exp_q.size()) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    timed_out = (n >= 3000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b out_data=%02h, required 1 0 00",
               in_ready, out_valid, out_data);
    end
    checks++;
    if (sentence_ok !== 1'b0 || sentence_err !== 1'b0 || in_sentence !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_status: ok=%b err=%b in_sentence=%b, required 0 0 0",
               sentence_ok, sentence_err, in_sentence);
    end
    checks++;
    if (err_cnt !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_err_cnt: err_cnt=%0d, required 0", err_cnt);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_valid_sentence();
    bq_t s = mk_sentence("$GPTXT,01*62");
    int  ok0, err0;
    bit  to;
    apply_reset();
    ready_mode = 0;
    ok0 = ok_pulses; err0 = err_pulses;
    send_seq(s, 0);
    drain(to);
    checks++;
    if (to || q_diffs(rcv_q, s) !== 0) begin
      errors++;
      $display("[TB] FAIL valid_stream: got %0d bytes (timeout=%b), required identical 14 bytes", rcv_q.size(), to);
    end
    checks++;
    if (ok_pulses - ok0 !== 1 || err_pulses - err0 !== 0) begin
      errors++;
      $display("[TB] FAIL valid_pulses: ok=%0d err=%0d, required 1 0", ok_pulses - ok0, err_pulses - err0);
    end
    checks++;
    if (err_cnt !== 16'h0000 || in_sentence !== 1'b0) begin
      errors++;
      $display("[TB] FAIL valid_after: err_cnt=%0d in_sentence=%b, required 0 0", err_cnt, in_sentence);
    end
  endtask

  task automatic test_bad_checksum();
    int ok0, err0;
    bit to;
    apply_reset();
    ok0 = ok_pulses; err0 = err_pulses;
    send_seq(mk_sentence("$GPTXT,01*63"), 1);
    drain(to);
    checks++;
    if (rcv_q.size() !== 0 || ok_pulses - ok0 !== 0 || err_pulses - err0 !== 1) begin
      errors++;
      $display("[TB] FAIL bad_checksum: out=%0d ok=%0d err=%0d, required 0 0 1",
               rcv_q.size(), ok_pulses - ok0, err_pulses - err0);
    end
    checks++;
    if (int'(err_cnt) !== cnt_if(1)) begin
      errors++;
      $display("[TB] FAIL bad_checksum_cnt: err_cnt=%0d, required %0d", err_cnt, cnt_if(1));
    end
  endtask

  task automatic test_garbage_prefix();
    bq_t s = mk_sentence("$GPTXT,01*62");
    bq_t g = mk_sentence("AB");
    int  ok0, err0;
    bit  to;
    apply_reset();
    ok0 = ok_pulses; err0 = err_pulses;
    send_seq(g, 0);
    send_seq(s, 0);
    drain(to);
    checks++;
    if (to || q_diffs(rcv_q, s) !== 0) begin
      errors++;
      $display("[TB] FAIL garbage_stream: got %0d bytes, required the 14-byte sentence", rcv_q.size());
    end
    checks++;
    if (ok_pulses - ok0 !== 1 || err_pulses - err0 !== 0 || err_cnt !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL garbage_status: ok=%0d err=%0d err_cnt=%0d, required 1 0 0",
               ok_pulses - ok0, err_pulses - err0, err_cnt);
    end
  endtask

  task automatic test_restart();
    bq_t s = mk_sentence("$GPTXT,01*62");
    bq_t p;
    int  ok0, err0;
    bit  to;
    p = {8'h24, 8'h47, 8'h50, 8'h54};
    apply_reset();
    ok0 = ok_pulses; err0 = err_pulses;
    send_seq(p, 0);
    drain(to);
    checks++;
    if (in_sentence !== 1'b1 || err_pulses - err0 !== 0) begin
      errors++;
      $display("[TB] FAIL restart_partial: in_sentence=%b err=%0d, required 1 0", in_sentence, err_pulses - err0);
    end
    send_seq(s, 0);
    drain(to);
    checks++;
    if (to || q_diffs(rcv_q, s) !== 0) begin
      errors++;
      $display("[TB] FAIL restart_stream: got %0d bytes, required the 14-byte sentence", rcv_q.size());
    end
    checks++;
    if (ok_pulses - ok0 !== 1 || err_pulses - err0 !== 1 || int'(err_cnt) !== cnt_if(1)) begin
      errors++;
      $display("[TB] FAIL restart_status: ok=%0d err=%0d err_cnt=%0d, required 1 1 %0d",
               ok_pulses - ok0, err_pulses - err0, err_cnt, cnt_if(1));
    end
  endtask

  task automatic test_overflow();
    bq_t head, tail;
    int  err0;
    bit  to;
    head.push_back(8'h24);
    repeat (81) head.push_back(8'h41);
    repeat (8) tail.push_back(8'h41);
    tail.push_back(8'h2A); tail.push_back(8'h30); tail.push_back(8'h30);
    tail.push_back(8'h0D); tail.push_back(8'h0A);
    apply_reset();
    err0 = err_pulses;
    send_seq(head, 0);
    drain(to);
    checks++;
    if (err_pulses - err0 !== 0 || in_sentence !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_82: err=%0d in_sentence=%b, required 0 1", err_pulses - err0, in_sentence);
    end
    send_byte(8'h41, 0);
    drain(to);
    checks++;
    if (err_pulses - err0 !== 1 || in_sentence !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_83: err=%0d in_sentence=%b, required 1 0", err_pulses - err0, in_sentence);
    end
    send_seq(tail, 0);
    drain(to);
    checks++;
    if (rcv_q.size() !== 0 || err_pulses - err0 !== 1 || int'(err_cnt) !== cnt_if(1)) begin
      errors++;
      $display("[TB] FAIL overflow_after: out=%0d err=%0d err_cnt=%0d, required 0 1 %0d",
               rcv_q.size(), err_pulses - err0, err_cnt, cnt_if(1));
    end
  endtask

  task automatic test_max_length();
    bq_t s82, s83;
    int  ok0, err0;
    bit  to;
    s82.push_back(8'h24);
    repeat (76) s82.push_back(8'h41);
    s82.push_back(8'h2A); s82.push_back(8'h30); s82.push_back(8'h30);
    s82.push_back(8'h0D); s82.push_back(8'h0A);
    s83.push_back(8'h24);
    repeat (77) s83.push_back(8'h41);
    s83.push_back(8'h2A); s83.push_back(8'h34); s83.push_back(8'h31);
    s83.push_back(8'h0D); s83.push_back(8'h0A);
    apply_reset();
    ready_mode = 1;
    ok0 = ok_pulses; err0 = err_pulses;
    send_seq(s82, 1);
    drain(to);
    checks++;
    if (to || q_diffs(rcv_q, s82) !== 0 || ok_pulses - ok0 !== 1) begin
      errors++;
      $display("[TB] FAIL max_len_82: got %0d bytes ok=%0d, required 82 bytes ok=1", rcv_q.size(), ok_pulses - ok0);
    end
    rcv_q.delete();
    send_seq(s83, 0);
    drain(to);
    checks++;
    if (rcv_q.size() !== 0 || err_pulses - err0 !== 1) begin
      errors++;
      $display("[TB] FAIL max_len_83: out=%0d err=%0d, required 0 1", rcv_q.size(), err_pulses - err0);
    end
    ready_mode = 0;
  endtask

  task automatic test_backpressure();
    bq_t s = mk_sentence("$GPTXT,01*62");
    int  bad = 0;
    bit  to;
    apply_reset();
    ready_mode = 2;
    send_seq(s, 0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_data !== 8'h24 || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL backpressure_hold: %0d of 10 stalled cycles wrong (out_valid=%b out_data=%02h in_ready=%b), required 0",
               bad, out_valid, out_data, in_ready);
    end
    ready_mode = 0;
    drain(to);
    checks++;
    if (to || q_diffs(rcv_q, s) !== 0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL backpressure_stream: got %0d bytes in_ready=%b, required 14 bytes and 1", rcv_q.size(), in_ready);
    end
  endtask

  task automatic test_reset_mid_dump();
    bq_t s = mk_sentence("$GPTXT,01*62");
    bit  to;
    apply_reset();
    ready_mode = 2;
    send_seq(s, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_dump_setup: out_valid=%b, required 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00 || in_sentence !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_dump_reset: out_valid=%b in_ready=%b out_data=%02h in_sentence=%b, required 0 1 00 0",
               out_valid, in_ready, out_data, in_sentence);
    end
    cur.delete();
    exp_q.delete();
    rcv_q.delete();
    model_cnt = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    ready_mode = 0;
    send_seq(s, 0);
    drain(to);
    checks++;
    if (to || q_diffs(rcv_q, s) !== 0) begin
      errors++;
      $display("[TB] FAIL after_reset_stream: got %0d bytes, required 14", rcv_q.size());
    end
  endtask

  task automatic gen_item();
    int  kind, blen, n;
    u8_t cs, c;
    item.delete();
    kind = $urandom_range(0, 7);
    if (kind == 5) begin
      repeat ($urandom_range(1, 6)) begin
        case ($urandom_range(0, 5))
          0:       c = 8'h24;
          1:       c = 8'h2A;
          2:       c = 8'h0D;
          3:       c = 8'h0A;
          4:       c = 8'h41;
          default: c = u8_t'($urandom_range(0, 255));
        endcase
        item.push_back(c);
      end
      return;
    end
    blen = (kind == 7) ? $urandom_range(70, 85) : $urandom_range(0, 20);
    cs = 8'h00;
    item.push_back(8'h24);
    for (int i = 0; i < blen; i++) begin
      do c = u8_t'($urandom_range(32, 126)); while (c == 8'h24 || c == 8'h2A);
      item.push_back(c);
      cs ^= c;
    end
    if (kind == 3) cs ^= u8_t'($urandom_range(1, 255));
    item.push_back(8'h2A);
    item.push_back(hex_char(cs[7:4]));
    item.push_back(hex_char(cs[3:0]));
    if (kind == 4) item[item.size() - 2] = 8'h67;
    item.push_back(8'h0D);
    item.push_back(8'h0A);
    if (kind == 6) begin
      n = $urandom_range(1, item.size() - 1);
      while (item.size() > n) void'(item.pop_back());
    end
  endtask

  task automatic test_random();
    int ok0, err0, mok0, merr0;
    bit to;
    apply_reset();
    ready_mode = 1;
    for (int r = 0; r < 4; r++) begin
      ok0 = ok_pulses; err0 = err_pulses; mok0 = model_ok; merr0 = model_err;
      rcv_q.delete();
      exp_q.delete();
      for (int k = 0; k < 15; k++) begin
        gen_item();
        send_seq(item, 2);
      end
      drain(to);
      checks++;
      if (to || q_diffs(rcv_q, exp_q) !== 0) begin
        errors++;
        $display("[TB] FAIL random_stream round %0d: got %0d bytes, required %0d (diffs=%0d)",
                 r, rcv_q.size(), exp_q.size(), q_diffs(rcv_q, exp_q));
      end
      checks++;
      if (ok_pulses - ok0 !== model_ok - mok0 || err_pulses - err0 !== model_err - merr0) begin
        errors++;
        $display("[TB] FAIL random_pulses round %0d: ok=%0d err=%0d, required %0d %0d",
                 r, ok_pulses - ok0, err_pulses - err0, model_ok - mok0, model_err - merr0);
      end
      checks++;
      if (int'(err_cnt) !== cnt_if(model_cnt)) begin
        errors++;
        $display("[TB] FAIL random_err_cnt round %0d: err_cnt=%0d, required %0d", r, err_cnt, cnt_if(model_cnt));
      end
    end
    ready_mode = 0;
  endtask

  // Scenario sequence
  initial begin
    $display("[TB] nmea_sentence_filter bench start");
    test_reset();
    test_valid_sentence();
    test_bad_checksum();
    test_garbage_prefix();
    test_restart();
    test_overflow();
    test_max_length();
    test_backpressure();
    test_reset_mid_dump();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
